negate_arbiter: RTL and testbench

NEGATE_ARBITER -- requirements
Module: negate_arbiter

---
 rtl/negate_arbiter.sv | 172 +++++++++++++++++
 tb/tb_negate_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/negate_arbiter.sv
// -----------------------------------------------------------------------------
// negate_arbiter
//
// Two-port round-robin arbiter in front of a shared two's-complement
// (negate) unit. A granted port's operand is issued to the unit and held
// stable until the unit answers or the wait times out. The result is then
// returned on that port with a one-cycle done pulse. A RELEASE state
// guarantees at least one idle cycle on unit_en between operations.
//
// Parameters
//   TIMEOUT     cycles in ISSUE without unit_ready before abort (1..15)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req0/a0, req1/a1    per-port request (held until done) and operand
//   done0/res0          port-0 completion pulse and last completed result
//   done1/res1          port-1 completion pulse and last completed result
//   err                 pulses with done when the operation timed out
//   busy                high whenever the FSM is not in IDLE
//   unit_en/unit_a      enable and operand to the shared unit
//   unit_ready/unit_out result-valid flag and result from the shared unit
// -----------------------------------------------------------------------------
module negate_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic       req1,
    input  logic [7:0] a1,
    output logic       done0,
    output logic [7:0] res0,
    output logic       done1,
    output logic [7:0] res1,
    output logic       err,
    output logic       busy,
    output logic       unit_en,
    output logic [7:0] unit_a,
    input  logic       unit_ready,
    input  logic [7:0] unit_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // The wait counter holds the number of low-ready cycles already seen,
    // so the abort fires on the cycle that would bring it up to TIMEOUT.
    localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic [3:0] cnt_q, cnt_d;
    logic       unit_en_q, unit_en_d;
    logic [7:0] unit_a_q, unit_a_d;
    logic [7:0] res0_q, res0_d;
    logic [7:0] res1_q, res1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        unit_en_d = unit_en_q;
        unit_a_d  = unit_a_q;
        res0_d    = res0_q;
        res1_d    = res1_q;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port not served last wins; otherwise the
                    // lone requester (req1 high means port 1 alone).
                    grant_d   = (req0 && req1) ? ~last_q : req1;
                    unit_a_d  = grant_d ? a1 : a0;
                    unit_en_d = 1'b1;
                    cnt_d     = 4'd0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (unit_ready) begin
                    if (grant_q) begin
                        res1_d  = unit_out;
                        done1_d = 1'b1;
                    end else begin
                        res0_d  = unit_out;
                        done0_d = 1'b1;
                    end
                    unit_en_d = 1'b0;
                    last_d    = grant_q;
                    state_d   = RELEASE;
                end else if (cnt_q == TMO_LAST) begin
                    // Abort: report completion with err, result untouched.
                    done0_d   = ~grant_q;
                    done1_d   = grant_q;
                    err_d     = 1'b1;
                    cnt_d     = cnt_q + 4'd1;
                    unit_en_d = 1'b0;
                    last_d    = grant_q;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RELEASE: begin
                // Wait for the unit to drop ready so a stale result is
                // never mistaken for the next operation's answer.
                if (!unit_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                unit_en_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= 4'd0;
            unit_en_q <= 1'b0;
            unit_a_q  <= 8'd0;
            res0_q    <= 8'd0;
            res1_q    <= 8'd0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            unit_en_q <= unit_en_d;
            unit_a_q  <= unit_a_d;
            res0_q    <= res0_d;
            res1_q    <= res1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign done0   = done0_q;
    assign done1   = done1_q;
    assign res0    = res0_q;
    assign res1    = res1_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign unit_en = unit_en_q;
    assign unit_a  = unit_a_q;

endmodule

// File: tb/tb_negate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_negate_arbiter
//
// Bench for negate_arbiter: a behavioural shared unit with configurable
// response latency (or no response at all), a scoreboard of expected
// completions checked whenever done0/done1 pulses, a vector table of
// single-port operations and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_negate_arbiter;

    localparam int TIMEOUT = 15;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] a0, a1;
    logic       done0, done1, err, busy, unit_en;
    logic [7:0] res0, res1, unit_a;
    logic       unit_ready;
    logic [7:0] unit_out;

    int total;
    int bad;

    negate_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .a0         (a0),
        .req1       (req1),
        .a1         (a1),
        .done0      (done0),
        .res0       (res0),
        .done1      (done1),
        .res1       (res1),
        .err        (err),
        .busy       (busy),
        .unit_en    (unit_en),
        .unit_a     (unit_a),
        .unit_ready (unit_ready),
        .unit_out   (unit_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared unit model: answers -unit_a lat_cfg edges after seeing unit_en.
    int   lat_cfg;
    logic never_cfg;
    int   ucnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_ready <= 1'b0;
            unit_out   <= 8'd0;
            ucnt       <= 0;
        end else if (unit_en) begin
            ucnt <= ucnt + 1;
            if (!never_cfg && (ucnt + 1 >= lat_cfg)) begin
                unit_ready <= 1'b1;
                unit_out   <= ~unit_a + 8'd1;
            end
        end else begin
            ucnt       <= 0;
            unit_ready <= 1'b0;
        end
    end

    typedef struct {
        logic       p;
        logic [7:0] res;
        logic       err;
    } sb_t;

    sb_t sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic p, input logic [7:0] r, input logic e);
        sb_t x;
        x.p   = p;
        x.res = r;
        x.err = e;
        sb.push_back(x);
    endtask

    // Completion monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done0 || done1) begin
                sb_t e;
                check("done_excl", {31'd0, done0 & done1}, 32'd0);
                check("unit_en_low_at_done", {31'd0, unit_en}, 32'd0);
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: done0=%0b done1=%0b with empty scoreboard at %0t",
                             done0, done1, $time);
                end else begin
                    e = sb.pop_front();
                    check("done_port", {31'd0, done1}, {31'd0, e.p});
                    check("res", {24'd0, (done1 ? res1 : res0)}, {24'd0, e.res});
                    check("err", {31'd0, err}, {31'd0, e.err});
                end
            end else if (err) begin
                total++;
                bad++;
                $display("FAIL err_without_done: err=1 done0=0 done1=0 at %0t", $time);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 10 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    // One single-port operation; chg swaps the operand mid-ISSUE.
    task automatic run_op(input logic p, input logic [7:0] a, input int l, input logic nv,
                          input logic [7:0] er, input logic ee, input logic chg);
        int   n;
        logic got;
        lat_cfg   = l;
        never_cfg = nv;
        push_exp(p, er, ee);
        if (p) begin a1 = a; req1 = 1'b1; end
        else   begin a0 = a; req0 = 1'b1; end
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            n++;
            if (chg && n == 3) begin
                check("unit_a_granted", {24'd0, unit_a}, {24'd0, a});
                if (p) a1 = ~a; else a0 = ~a;
            end
            if (chg && n == 4)
                check("unit_a_hold", {24'd0, unit_a}, {24'd0, a});
            if (p ? done1 : done0) got = 1'b1;
        end
        if (p) req1 = 1'b0; else req0 = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
        check("latency", n, nv ? TIMEOUT + 1 : l + 2);
        wait_idle();
    endtask

    // Both requests held until n completions; grants must alternate 0,1,...
    task automatic hold_both(input int n, input logic [7:0] x0, input logic [7:0] x1);
        int cnt;
        for (int k = 0; k < n; k++) begin
            if (k % 2 == 0) push_exp(1'b0, ~x0 + 8'd1, 1'b0);
            else            push_exp(1'b1, ~x1 + 8'd1, 1'b0);
        end
        lat_cfg   = 1;
        never_cfg = 1'b0;
        a0   = x0;
        a1   = x1;
        req0 = 1'b1;
        req1 = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 300 && cnt < n; i++) begin
            @(posedge clk); #1;
            if (done0 || done1) cnt++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("hold_count", cnt, n);
        wait_idle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       p;
        logic [7:0] a;
        int         lat;
        logic       never;
        logic [7:0] exp_res;
        logic       exp_err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req0      = 1'b0;
        req1      = 1'b0;
        a0        = 8'd0;
        a1        = 8'd0;
        lat_cfg   = 1;
        never_cfg = 1'b0;

        tbl[0] = '{1'b0, 8'd12,  2, 1'b0, 8'hF4, 1'b0};
        tbl[1] = '{1'b1, 8'h7F,  1, 1'b0, 8'h81, 1'b0};
        tbl[2] = '{1'b0, 8'h80,  3, 1'b0, 8'h80, 1'b0};
        tbl[3] = '{1'b0, 8'h55,  1, 1'b1, 8'h80, 1'b1};
        tbl[4] = '{1'b1, 8'h00,  1, 1'b0, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 8'h33,  1, 1'b1, 8'h00, 1'b1};
        tbl[6] = '{1'b0, 8'hFF,  5, 1'b0, 8'h01, 1'b0};

        #3;
        check("reset_outs", {11'd0, done0, done1, err, busy, unit_en, unit_a, res0, res1}, 32'd0);
        do_reset();
        check("post_reset_outs", {11'd0, done0, done1, err, busy, unit_en, unit_a, res0, res1}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].p, tbl[i].a, tbl[i].lat, tbl[i].never,
                   tbl[i].exp_res, tbl[i].exp_err, 1'b0);
            if (i == 0) begin
                check("res1_untouched", {24'd0, res1}, 32'd0);
                check("err_clear", {31'd0, err}, 32'd0);
            end
        end

        // Fresh reset so the first tie goes to port 0.
        do_reset();
        hold_both(2, 8'h01, 8'h80);
        hold_both(4, 8'h10, 8'h03);

        // Operand change during ISSUE must not reach the unit.
        run_op(1'b0, 8'h21, 4, 1'b0, 8'hDF, 1'b0, 1'b1);

        // Reset in the middle of ISSUE aborts with no done pulse.
        lat_cfg   = 1;
        never_cfg = 1'b1;
        a0   = 8'h44;
        req0 = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("unit_en_in_issue", {31'd0, unit_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outs", {11'd0, done0, done1, err, busy, unit_en, unit_a, res0, res1}, 32'd0);
        req0      = 1'b0;
        never_cfg = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_after_reset", {31'd0, busy}, 32'd0);
        run_op(1'b1, 8'h00, 1, 1'b0, 8'h00, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
